obstacle_spawn_scheduler: RTL
=============================

// Module: obstacle_spawn_scheduler
// PURPOSE
//  Sequences a pool of NUM_SLOTS triangle obstacle instances on the frame clock.
//  Walks a fixed level pattern of {gap, flipped} entries and fires one-frame start
//  pulses into free obstacle slots, round-robin.
//  Stops spawning on any slot collision and counts cleared obstacles for the score display.
//  Sits between the game top level (start button, score/game-over display) and the obstacle instances.
// PARAMETERS
//  NUM_SLOTS    4   number of obstacle instances managed (2..8)
//  PATTERN_LEN  8   entries in internal pattern ROM; index wraps to 0 after last
//  SCORE_MAX    999 score saturation value
// PORTS
//  frame_clk      in   1          frame clock, one tick per video frame
//  Reset          in   1          synchronous, active-high reset
//  start_game     in   1          level-sampled start request; acted on in IDLE and DEAD
//  slot_busy      in   NUM_SLOTS  slot k obstacle is on screen (moving)
//  slot_collide   in   NUM_SLOTS  slot k reports player collision this frame
//  spawn          out  NUM_SLOTS  one-hot, one-frame pulse; slot k starts moving
//  spawn_flipped  out  1          ceiling placement for the slot pulsed this frame; held between spawns
//  game_over      out  1          high in DEAD
//  running        out  1          high in RUN
//  score          out  10         obstacles cleared this run, saturating at SCORE_MAX
// BEHAVIOUR
//  Reset (sampled on frame_clk): state=IDLE, spawn=0, spawn_flipped=0, game_over=0, running=0, score=0.
//   Also clears pattern idx=0, gap_cnt=0, rr_ptr=0, pend=0 and busy_q=0.
//  Pattern ROM entry {gap[7:0], flip}, in order:
//   {40,0} {30,1} {50,0} {20,0} {45,1} {35,0} {60,1} {25,0}
//   A gap of 0 is treated as 1.
//  FSM, all outputs registered:
//   IDLE: start_game=1 -> RUN with idx=0, gap_cnt=gap[0], score=0, rr_ptr=0.
//   RUN:
//    - Any bit of slot_collide=1 -> DEAD next edge. No spawn is issued on that edge: collide beats spawn.
//    - Else if gap_cnt!=0: gap_cnt decrements by 1.
//    - Else (gap_cnt==0), slot choice: first slot k with slot_busy[k]=0 and pend[k]=0.
//      The search starts at rr_ptr and wraps modulo NUM_SLOTS.
//    - If a slot is found:
//      - spawn[k]=1 for exactly one frame; spawn_flipped=flip[idx].
//      - pend[k] is set for that one frame.
//      - rr_ptr=(k+1)%NUM_SLOTS; idx=(idx+1)%PATTERN_LEN; gap_cnt=gap[new idx].
//    - If none is found: stall with gap_cnt held at 0; idx and rr_ptr unchanged; retry next frame.
//   DEAD: spawn=0, game_over=1, score frozen.
//    start_game=1 -> RUN directly, with the same reload as in IDLE: score=0, idx=0.
//  pend: a slot spawned on edge t counts as busy on edge t+1, since slot_busy lags by one frame.
//   pend is cleared after one frame.
//  Score: busy_q is the registered slot_busy.
//   In RUN, each falling edge (busy_q[k]=1, slot_busy[k]=0) with slot_collide[k]=0 adds 1.
//   Several falls in the same frame add their popcount.
//   The sum is clamped to SCORE_MAX.
//  Spawn-to-spawn latency is gap+1 frames when a slot is free.
//  First spawn after start is gap[0]+1 frames after the start edge.
//  Reset asserted mid-run overrides everything on that edge, including a coincident collide or spawn.
// TESTING
//  1. Reset, start_game 1 frame, all slots free -> first spawn=4'b0001 at frame 41 with flipped=0.
//     Next: spawn=4'b0010 31 frames later with flipped=1.
//  2. slot_busy=4'b1111 when gap expires -> no spawn, gap_cnt holds at 0.
//     Drop slot_busy[2] -> spawn=4'b0100 on the next edge; pattern idx is not skipped.
//  3. slot_collide[1]=1 on the same frame gap_cnt==0 -> spawn stays 0, game_over=1, running=0.
//     start_game -> RUN, score=0, next spawn after 41 frames.
//  4. Two slots fall busy->idle in one frame with no collide -> score +2.
//     Preload the count to 998 -> score=999 and holds at 999.
//  5. Run 8 spawns -> the 9th uses entry 0 (gap 40, flip 0); rr_ptr cycles 0,1,2,3,0.
//  6. Assert Reset while spawn is pulsing -> next edge all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/obstacle_spawn_scheduler.sv
// rtl/obstacle_spawn_scheduler.sv - level-pattern obstacle spawner with round-robin slot choice and score
module obstacle_spawn_scheduler #(
  parameter int NUM_SLOTS   = 4,
  parameter int PATTERN_LEN = 8,
  parameter int SCORE_MAX   = 999
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic                 start_game,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  input  logic [NUM_SLOTS-1:0] slot_collide,
  output logic [NUM_SLOTS-1:0] spawn,
  output logic                 spawn_flipped,
  output logic                 game_over,
  output logic                 running,
  output logic [9:0]           score
);

  localparam int IW = $clog2(PATTERN_LEN);
  localparam int SW = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  state_t               state, state_n;
  logic [IW-1:0]        idx, idx_n;
  logic [7:0]           gap_cnt, gap_cnt_n;
  logic [SW-1:0]        rr_ptr, rr_ptr_n;
  logic [NUM_SLOTS-1:0] pend, pend_n;
  logic [NUM_SLOTS-1:0] busy_q, busy_q_n;
  logic [NUM_SLOTS-1:0] spawn_n;
  logic                 flip_n, game_over_n, running_n;
  logic [9:0]           score_n;
  logic [NUM_SLOTS-1:0] falls;
  logic                 found;
  logic [SW-1:0]        sel, cand;
  int                   fall_cnt, score_sum;

  function automatic logic [7:0] gap_of(input int i);
    logic [7:0] g;
    case (i % 8)
      0:       g = 8'd40;
      1:       g = 8'd30;
      2:       g = 8'd50;
      3:       g = 8'd20;
      4:       g = 8'd45;
      5:       g = 8'd35;
      6:       g = 8'd60;
      default: g = 8'd25;
    endcase
    return (g == 8'd0) ? 8'd1 : g;
  endfunction

  function automatic logic flip_of(input int i);
    case (i % 8)
      1, 4, 6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    gap_cnt_n = gap_cnt;
    rr_ptr_n  = rr_ptr;
    pend_n    = '0;
    busy_q_n  = slot_busy;
    spawn_n   = '0;
    flip_n    = spawn_flipped;
    score_n   = score;
    found     = 1'b0;
    sel       = '0;
    cand      = '0;
    fall_cnt  = 0;

    // Cleared obstacles: slots that just went idle without being the collider.
    falls = busy_q & ~slot_busy & ~slot_collide;
    for (int k = 0; k < NUM_SLOTS; k++) fall_cnt += int'(falls[k]);
    score_sum = int'(score) + fall_cnt;

    for (int j = 0; j < NUM_SLOTS; j++) begin
      cand = SW'((int'(rr_ptr) + j) % NUM_SLOTS);
      if (!found && !slot_busy[cand] && !pend[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    case (state)
      S_RUN: begin
        score_n = (score_sum > SCORE_MAX) ? 10'(SCORE_MAX) : 10'(score_sum);
        if (|slot_collide) begin
          state_n = S_DEAD;
        end else if (gap_cnt != 8'd0) begin
          gap_cnt_n = gap_cnt - 8'd1;
        end else if (found) begin
          spawn_n[sel] = 1'b1;
          pend_n[sel]  = 1'b1;
          flip_n       = flip_of(int'(idx));
          rr_ptr_n     = (sel == SW'(NUM_SLOTS - 1)) ? '0 : sel + 1'b1;
          idx_n        = (idx == IW'(PATTERN_LEN - 1)) ? '0 : idx + 1'b1;
          gap_cnt_n    = gap_of(int'(idx_n));
        end
      end
      S_IDLE, S_DEAD: begin
        if (start_game) begin
          state_n   = S_RUN;
          idx_n     = '0;
          gap_cnt_n = gap_of(0);
          rr_ptr_n  = '0;
          score_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    running_n   = (state_n == S_RUN);
    game_over_n = (state_n == S_DEAD);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      gap_cnt       <= '0;
      rr_ptr        <= '0;
      pend          <= '0;
      busy_q        <= '0;
      spawn         <= '0;
      spawn_flipped <= 1'b0;
      game_over     <= 1'b0;
      running       <= 1'b0;
      score         <= '0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      gap_cnt       <= gap_cnt_n;
      rr_ptr        <= rr_ptr_n;
      pend          <= pend_n;
      busy_q        <= busy_q_n;
      spawn         <= spawn_n;
      spawn_flipped <= flip_n;
      game_over     <= game_over_n;
      running       <= running_n;
      score         <= score_n;
    end
  end

endmodule
